// File: rtl/credit_start_ctrl.sv
// Start/game-sequence controller: debounces the start buttons, debits 1 or 2 credits, then runs INIT/PLAY/OVER.
// Optional macro FREE_PLAY_EN: ignore credits, skip the debit pulse, blink both lamps in attract.
module credit_start_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int PULSE_CYC    = 4,
    parameter int OVER_HOLD    = 64,
    parameter int BLINK_LOG2   = 4
) (
    input  logic i_clk_drv,
    input  logic i_rst_n,
    input  logic i_start1,
    input  logic i_start2,
    input  logic i_1_or_2_credit,
    input  logic i_2_credit,
    input  logic i_game_over,
    output logic o_1_cr_start_n,
    output logic o_2_cr_start,
    output logic o_game_init,
    output logic o_attract,
    output logic o_play2,
    output logic o_lamp1,
    output logic o_lamp2
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int CNT_MAX = (PULSE_CYC > OVER_HOLD) ? PULSE_CYC : OVER_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BL_W    = BLINK_LOG2 + 1;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_DEBIT   = 3'd1,
        ST_INIT    = 3'd2,
        ST_PLAY    = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BL_W-1:0]   r_blink_cnt;
    logic              r_play2;
    logic [1:0]        w_raw;
    logic [1:0]        w_evt;
    logic              w_blink;
    logic              w_start1;
    logic              w_start2;

    assign w_raw = {i_start2, i_start1};

    // Run-length debouncer: the level follows the raw input once it has been sampled equal DEBOUNCE_CYC times in a row.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic            r_prev;
            logic            r_deb;
            logic            r_deb_d;
            logic [DB_W-1:0] r_run;
            logic [DB_W-1:0] w_run_next;

            assign w_run_next = (w_raw[gi] != r_prev)              ? DB_W'(1) :
                                (r_run == DB_W'(DEBOUNCE_CYC))      ? r_run    :
                                                                      r_run + DB_W'(1);

            always_ff @(posedge i_clk_drv or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_prev  <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_run   <= '0;
                end else begin
                    r_prev  <= w_raw[gi];
                    r_run   <= w_run_next;
                    r_deb_d <= r_deb;
                    if (w_run_next == DB_W'(DEBOUNCE_CYC)) begin
                        r_deb <= w_raw[gi];
                    end
                end
            end

            assign w_evt[gi] = r_deb & ~r_deb_d;
        end
    endgenerate

`ifdef FREE_PLAY_EN
    assign w_start1 = w_evt[0];
    assign w_start2 = w_evt[1];
`else
    assign w_start1 = w_evt[0] & i_1_or_2_credit;
    assign w_start2 = w_evt[1] & i_2_credit;
`endif

    always_ff @(posedge i_clk_drv or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BL_W'(1);
        end
    end

    assign w_blink = r_blink_cnt[BLINK_LOG2];

    always_ff @(posedge i_clk_drv or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ATTRACT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ATTRACT: begin
                if (w_start1 || w_start2) begin
`ifdef FREE_PLAY_EN
                    w_state_next = ST_INIT;
`else
                    w_state_next = ST_DEBIT;
`endif
                end
            end
            ST_DEBIT: begin
                if (r_cnt == CNT_W'(PULSE_CYC - 1)) begin
                    w_state_next = ST_INIT;
                end
            end
            ST_INIT:  w_state_next = ST_PLAY;
            ST_PLAY: begin
                if (i_game_over) begin
                    w_state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (r_cnt == CNT_W'(OVER_HOLD - 1)) begin
                    w_state_next = ST_ATTRACT;
                end
            end
            default:  w_state_next = ST_ATTRACT;
        endcase
    end

    // Shared DEBIT/OVER timer, cleared on every state change and saturating otherwise.
    always_ff @(posedge i_clk_drv or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk_drv or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_play2 <= 1'b0;
        end else if (r_state == ST_ATTRACT && (w_start1 || w_start2)) begin
            r_play2 <= w_start2;
        end
    end

    assign o_play2 = r_play2;

    always_comb begin
        o_1_cr_start_n = 1'b1;
        o_2_cr_start   = 1'b0;
        o_game_init    = 1'b0;
        o_attract      = 1'b0;
        o_lamp1        = 1'b0;
        o_lamp2        = 1'b0;
        case (r_state)
            ST_ATTRACT: begin
                o_attract = 1'b1;
`ifdef FREE_PLAY_EN
                o_lamp1   = w_blink;
                o_lamp2   = w_blink;
`else
                o_lamp1   = w_blink & i_1_or_2_credit;
                o_lamp2   = w_blink & i_2_credit;
`endif
            end
            ST_DEBIT: begin
                o_1_cr_start_n = r_play2;
                o_2_cr_start   = r_play2;
            end
            ST_INIT:  o_game_init = 1'b1;
            default:  ;
        endcase
    end

endmodule
